// File: rtl/ndata_width_ratio_converter.sv
// Element-stream width converter: packs IN_WIDTH-element beats into OUT_WIDTH-element
// beats (upsize) or slices them apart (downsize) for any integer ratio. Equal widths
// collapse to wires. Output side is registered and lossless under backpressure.
module ndata_width_ratio_converter #(
    parameter int DATA_W     = 8,
    parameter int IN_WIDTH   = 4,
    parameter int OUT_WIDTH  = 8,
    parameter int DROP_EMPTY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_WIDTH*DATA_W-1:0]    in_data,
    input  logic [IN_WIDTH-1:0]           in_keep,
    input  logic                          in_last,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [OUT_WIDTH*DATA_W-1:0]   out_data,
    output logic [OUT_WIDTH-1:0]          out_keep,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready
);

    localparam int IN_BITS  = IN_WIDTH * DATA_W;
    localparam int OUT_BITS = OUT_WIDTH * DATA_W;
    localparam int RATIO    = (OUT_WIDTH >= IN_WIDTH) ? OUT_WIDTH / IN_WIDTH
                                                      : IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

    // Parameter legality: one width must divide the other, DROP_EMPTY is a flag.
    if ((IN_WIDTH < 1) || (OUT_WIDTH < 1) ||
        (((IN_WIDTH % OUT_WIDTH) != 0) && ((OUT_WIDTH % IN_WIDTH) != 0))) begin : g_bad_ratio
        $error("ndata_width_ratio_converter: IN_WIDTH and OUT_WIDTH must be integer multiples");
    end
    if ((DROP_EMPTY != 0) && (DROP_EMPTY != 1)) begin : g_bad_drop
        $error("ndata_width_ratio_converter: DROP_EMPTY must be 0 or 1");
    end

    if (IN_WIDTH == OUT_WIDTH) begin : g_pass
        assign out_data  = in_data;
        assign out_keep  = in_keep;
        assign out_last  = in_last;
        assign out_valid = in_valid;
        assign in_ready  = out_ready;

    end else if (OUT_WIDTH > IN_WIDTH) begin : g_up
        logic [IDX_W-1:0]     slot_q, slot_d;
        logic [OUT_BITS-1:0]  acc_data_q, acc_data_d;
        logic [OUT_WIDTH-1:0] acc_keep_q, acc_keep_d;
        logic [OUT_BITS-1:0]  merged_data;
        logic [OUT_WIDTH-1:0] merged_keep;
        logic [OUT_BITS-1:0]  out_data_q, out_data_d;
        logic [OUT_WIDTH-1:0] out_keep_q, out_keep_d;
        logic                 out_last_q, out_last_d;
        logic                 out_valid_q, out_valid_d;
        logic                 accept;

        // The output register may only be refilled once it is empty or draining.
        assign in_ready  = !rst && (!out_valid_q || out_ready);
        assign accept    = in_valid && in_ready;
        assign out_data  = out_data_q;
        assign out_keep  = out_keep_q;
        assign out_last  = out_last_q;
        assign out_valid = out_valid_q;

        // Merge the incoming beat into its slot; slot 0 starts a fresh, zeroed word.
        always_comb begin
            merged_data = (slot_q == '0) ? '0 : acc_data_q;
            merged_keep = (slot_q == '0) ? '0 : acc_keep_q;
            merged_data[int'(slot_q)*IN_BITS +: IN_BITS]   = in_data;
            merged_keep[int'(slot_q)*IN_WIDTH +: IN_WIDTH] = in_keep;

            slot_d      = slot_q;
            acc_data_d  = acc_data_q;
            acc_keep_d  = acc_keep_q;
            out_data_d  = out_data_q;
            out_keep_d  = out_keep_q;
            out_last_d  = out_last_q;
            out_valid_d = out_valid_q;

            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                if ((slot_q == IDX_W'(RATIO - 1)) || in_last) begin
                    out_data_d  = merged_data;
                    out_keep_d  = merged_keep;
                    out_last_d  = in_last;
                    out_valid_d = 1'b1;
                    slot_d      = '0;
                end else begin
                    acc_data_d  = merged_data;
                    acc_keep_d  = merged_keep;
                    slot_d      = slot_q + 1'b1;
                end
            end
        end

        // Control state: cleared by reset, which also drops any partial word.
        always_ff @(posedge clk) begin
            if (rst) begin
                slot_q      <= '0;
                out_valid_q <= 1'b0;
            end else begin
                slot_q      <= slot_d;
                out_valid_q <= out_valid_d;
            end
        end

        // Payload registers carry no reset.
        always_ff @(posedge clk) begin
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
            out_last_q <= out_last_d;
        end

    end else begin : g_down
        logic [IDX_W-1:0]    sl_q, sl_d;
        logic [IN_BITS-1:0]  hold_data_q, hold_data_d;
        logic [IN_WIDTH-1:0] hold_keep_q, hold_keep_d;
        logic                hold_last_q, hold_last_d;
        logic                held_q, held_d;
        logic                upper_empty;
        logic                is_final;
        logic                accept;

        // A new beat is taken only when nothing is held or the last slice leaves now.
        assign in_ready  = !rst && (!held_q || (out_ready && is_final));
        assign accept    = in_valid && in_ready;
        assign out_data  = hold_data_q[int'(sl_q)*OUT_BITS +: OUT_BITS];
        assign out_keep  = hold_keep_q[int'(sl_q)*OUT_WIDTH +: OUT_WIDTH];
        assign out_last  = hold_last_q && is_final;
        assign out_valid = held_q;

        // Slice sequencing: a slice is final at the top index, or when every slice
        // above it is empty and empty tails are dropped.
        always_comb begin
            upper_empty = 1'b1;
            for (int s = 0; s < RATIO; s++) begin
                if ((s > int'(sl_q)) && (hold_keep_q[s*OUT_WIDTH +: OUT_WIDTH] != '0)) begin
                    upper_empty = 1'b0;
                end
            end
            is_final = (sl_q == IDX_W'(RATIO - 1)) || ((DROP_EMPTY != 0) && upper_empty);

            sl_d        = sl_q;
            held_d      = held_q;
            hold_data_d = hold_data_q;
            hold_keep_d = hold_keep_q;
            hold_last_d = hold_last_q;

            if (held_q && out_ready) begin
                if (is_final) begin
                    sl_d   = '0;
                    held_d = 1'b0;
                end else begin
                    sl_d   = sl_q + 1'b1;
                end
            end
            if (accept) begin
                hold_data_d = in_data;
                hold_keep_d = in_keep;
                hold_last_d = in_last;
                held_d      = 1'b1;
                sl_d        = '0;
            end
        end

        // Control state: cleared by reset, which discards any held slices.
        always_ff @(posedge clk) begin
            if (rst) begin
                sl_q   <= '0;
                held_q <= 1'b0;
            end else begin
                sl_q   <= sl_d;
                held_q <= held_d;
            end
        end

        // Payload registers carry no reset.
        always_ff @(posedge clk) begin
            hold_data_q <= hold_data_d;
            hold_keep_q <= hold_keep_d;
            hold_last_q <= hold_last_d;
        end
    end

endmodule

// File: tb/tb_ndata_width_ratio_converter.sv
// Bench for ndata_width_ratio_converter: directed scenarios plus randomized traffic
// with backpressure, checked against a packet-level reference model.
module tb_ndata_width_ratio_converter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Upsize 4 -> 12 (R=3)
    logic [31:0] u_in_data;  logic [3:0]  u_in_keep;  logic u_in_last, u_in_valid, u_in_ready;
    logic [95:0] u_out_data; logic [11:0] u_out_keep; logic u_out_last, u_out_valid, u_out_ready;
    // Downsize 12 -> 4, DROP_EMPTY=1
    logic [95:0] d_in_data;  logic [11:0] d_in_keep;  logic d_in_last, d_in_valid, d_in_ready;
    logic [31:0] d_out_data; logic [3:0]  d_out_keep; logic d_out_last, d_out_valid, d_out_ready;
    // Downsize 12 -> 4, DROP_EMPTY=0
    logic [95:0] z_in_data;  logic [11:0] z_in_keep;  logic z_in_last, z_in_valid, z_in_ready;
    logic [31:0] z_out_data; logic [3:0]  z_out_keep; logic z_out_last, z_out_valid, z_out_ready;
    // Downsize 8 -> 2, DROP_EMPTY=1
    logic [63:0] e_in_data;  logic [7:0]  e_in_keep;  logic e_in_last, e_in_valid, e_in_ready;
    logic [15:0] e_out_data; logic [1:0]  e_out_keep; logic e_out_last, e_out_valid, e_out_ready;
    // Equal 4 -> 4
    logic [31:0] p_in_data;  logic [3:0]  p_in_keep;  logic p_in_last, p_in_valid, p_in_ready;
    logic [31:0] p_out_data; logic [3:0]  p_out_keep; logic p_out_last, p_out_valid, p_out_ready;

    ndata_width_ratio_converter #(.DATA_W(8), .IN_WIDTH(4), .OUT_WIDTH(12), .DROP_EMPTY(1)) u_up (
        .clk(clk), .rst(rst),
        .in_data(u_in_data), .in_keep(u_in_keep), .in_last(u_in_last), .in_valid(u_in_valid), .in_ready(u_in_ready),
        .out_data(u_out_data), .out_keep(u_out_keep), .out_last(u_out_last), .out_valid(u_out_valid), .out_ready(u_out_ready));

    ndata_width_ratio_converter #(.DATA_W(8), .IN_WIDTH(12), .OUT_WIDTH(4), .DROP_EMPTY(1)) u_dn (
        .clk(clk), .rst(rst),
        .in_data(d_in_data), .in_keep(d_in_keep), .in_last(d_in_last), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .out_data(d_out_data), .out_keep(d_out_keep), .out_last(d_out_last), .out_valid(d_out_valid), .out_ready(d_out_ready));

    ndata_width_ratio_converter #(.DATA_W(8), .IN_WIDTH(12), .OUT_WIDTH(4), .DROP_EMPTY(0)) u_dn0 (
        .clk(clk), .rst(rst),
        .in_data(z_in_data), .in_keep(z_in_keep), .in_last(z_in_last), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .out_data(z_out_data), .out_keep(z_out_keep), .out_last(z_out_last), .out_valid(z_out_valid), .out_ready(z_out_ready));

    ndata_width_ratio_converter #(.DATA_W(8), .IN_WIDTH(8), .OUT_WIDTH(2), .DROP_EMPTY(1)) u_dn82 (
        .clk(clk), .rst(rst),
        .in_data(e_in_data), .in_keep(e_in_keep), .in_last(e_in_last), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .out_data(e_out_data), .out_keep(e_out_keep), .out_last(e_out_last), .out_valid(e_out_valid), .out_ready(e_out_ready));

    ndata_width_ratio_converter #(.DATA_W(8), .IN_WIDTH(4), .OUT_WIDTH(4), .DROP_EMPTY(1)) u_eq (
        .clk(clk), .rst(rst),
        .in_data(p_in_data), .in_keep(p_in_keep), .in_last(p_in_last), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .out_data(p_out_data), .out_keep(p_out_keep), .out_last(p_out_last), .out_valid(p_out_valid), .out_ready(p_out_ready));

    // Drive one upsize beat with out_ready high; returns just after the accepting edge.
    task automatic up_drive(input logic [31:0] d, input logic [3:0] k, input logic l);
        @(negedge clk);
        u_in_data = d; u_in_keep = k; u_in_last = l; u_in_valid = 1'b1;
        @(posedge clk); #1;
        u_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({u_out_valid, u_in_ready, d_out_valid, d_in_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_state: up v/r dn v/r = %b, expected 0000", {u_out_valid, u_in_ready, d_out_valid, d_in_ready});
        end
        n_vec++;
        if ({z_out_valid, z_in_ready, e_out_valid, e_in_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_state2: dn0 v/r dn82 v/r = %b, expected 0000", {z_out_valid, z_in_ready, e_out_valid, e_in_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if ({u_in_ready, d_in_ready, z_in_ready, e_in_ready} !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b, expected 1111", {u_in_ready, d_in_ready, z_in_ready, e_in_ready});
        end
    endtask

    task automatic test_passthrough();
        logic [37:0] exp_v;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            p_in_data = $urandom; p_in_keep = 4'($urandom); p_in_last = 1'($urandom);
            p_in_valid = 1'($urandom); p_out_ready = (i != 1);
            exp_v = {p_in_valid, p_in_last, p_in_keep, p_in_data};
            #1;
            n_vec++;
            if ({p_out_valid, p_out_last, p_out_keep, p_out_data, p_in_ready} !== {exp_v, p_out_ready}) begin
                n_err++;
                $display("FAIL passthrough[%0d]: got %h expected %h", i,
                         {p_out_valid, p_out_last, p_out_keep, p_out_data, p_in_ready}, {exp_v, p_out_ready});
            end
        end
    endtask

    task automatic test_up_steady();
        logic [31:0]  bt [6];
        logic [109:0] exp_v;
        for (int k = 0; k < 6; k++) bt[k] = $urandom;
        u_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            u_in_data = bt[k]; u_in_keep = 4'hF; u_in_last = (k == 5); u_in_valid = 1'b1;
            #1;
            n_vec++;
            if (u_in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL up_steady_ready[%0d]: got %b expected 1", k, u_in_ready);
            end
            @(posedge clk); #1;
            u_in_valid = 1'b0;
            n_vec++;
            if (k == 2 || k == 5) begin
                exp_v = {1'b1, (k == 5), 12'hFFF, bt[k], bt[k-1], bt[k-2]};
                if ({u_out_valid, u_out_last, u_out_keep, u_out_data} !== exp_v) begin
                    n_err++;
                    $display("FAIL up_steady_out[%0d]: got %h expected %h", k,
                             {u_out_valid, u_out_last, u_out_keep, u_out_data}, exp_v);
                end
            end else if (u_out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL up_steady_idle[%0d]: out_valid=%b expected 0", k, u_out_valid);
            end
        end
        @(posedge clk); #1;
        n_vec++;
        if (u_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL up_steady_drain: out_valid=%b expected 0", u_out_valid);
        end
    endtask

    task automatic test_up_short();
        logic [109:0] exp_v;
        u_out_ready = 1'b1;
        up_drive(32'h44332211, 4'hF, 1'b0);
        n_vec++;
        if (u_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL up_short_early: out_valid=%b expected 0", u_out_valid);
        end
        up_drive(32'h88776655, 4'h3, 1'b1);
        exp_v = {1'b1, 1'b1, 12'h03F, 32'h0, 32'h88776655, 32'h44332211};
        n_vec++;
        if ({u_out_valid, u_out_last, u_out_keep, u_out_data} !== exp_v) begin
            n_err++;
            $display("FAIL up_short_out: got %h expected %h", {u_out_valid, u_out_last, u_out_keep, u_out_data}, exp_v);
        end
        up_drive(32'hA3A2A1A0, 4'hF, 1'b0);
        up_drive(32'hB3B2B1B0, 4'h9, 1'b0);
        up_drive(32'hC3C2C1C0, 4'hF, 1'b1);
        exp_v = {1'b1, 1'b1, 12'hF9F, 32'hC3C2C1C0, 32'hB3B2B1B0, 32'hA3A2A1A0};
        n_vec++;
        if ({u_out_valid, u_out_last, u_out_keep, u_out_data} !== exp_v) begin
            n_err++;
            $display("FAIL up_short_restart: got %h expected %h", {u_out_valid, u_out_last, u_out_keep, u_out_data}, exp_v);
        end
    endtask

    task automatic test_down_drop();
        logic [95:0] bd;
        bd = {$urandom, $urandom, $urandom};
        d_out_ready = 1'b1; z_out_ready = 1'b1;
        @(negedge clk);
        d_in_data = bd; d_in_keep = 12'h0FF; d_in_last = 1'b1; d_in_valid = 1'b1;
        z_in_data = bd; z_in_keep = 12'h0FF; z_in_last = 1'b1; z_in_valid = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0; z_in_valid = 1'b0;
        n_vec++;
        if ({d_out_valid, d_out_last, d_out_keep, d_out_data, z_out_valid, z_out_last, z_out_keep, z_out_data}
            !== {1'b1, 1'b0, 4'hF, bd[31:0], 1'b1, 1'b0, 4'hF, bd[31:0]}) begin
            n_err++;
            $display("FAIL down_slice0: drop1=%h drop0=%h expected %h",
                     {d_out_valid, d_out_last, d_out_keep, d_out_data}, {z_out_valid, z_out_last, z_out_keep, z_out_data},
                     {1'b1, 1'b0, 4'hF, bd[31:0]});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({d_out_valid, d_out_last, d_out_keep, d_out_data, z_out_valid, z_out_last, z_out_keep, z_out_data}
            !== {1'b1, 1'b1, 4'hF, bd[63:32], 1'b1, 1'b0, 4'hF, bd[63:32]}) begin
            n_err++;
            $display("FAIL down_slice1: drop1=%h drop0=%h expected %h / %h",
                     {d_out_valid, d_out_last, d_out_keep, d_out_data}, {z_out_valid, z_out_last, z_out_keep, z_out_data},
                     {1'b1, 1'b1, 4'hF, bd[63:32]}, {1'b1, 1'b0, 4'hF, bd[63:32]});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({d_out_valid, z_out_valid, z_out_last, z_out_keep, z_out_data} !== {1'b0, 1'b1, 1'b1, 4'h0, bd[95:64]}) begin
            n_err++;
            $display("FAIL down_slice2: drop1 valid=%b drop0=%h expected 0 / %h", d_out_valid,
                     {z_out_valid, z_out_last, z_out_keep, z_out_data}, {1'b1, 1'b1, 4'h0, bd[95:64]});
        end
        @(posedge clk); #1;
        n_vec++;
        if (z_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL down_drop0_end: out_valid=%b expected 0", z_out_valid);
        end
    endtask

    task automatic test_zero_keep();
        logic [63:0] bd;
        logic [7:0]  kk [3];
        logic        ll [3];
        int          nsl [3];
        logic [1:0]  ek;
        kk[0] = 8'h00; ll[0] = 1'b1; nsl[0] = 1;
        kk[1] = 8'h00; ll[1] = 1'b0; nsl[1] = 1;
        kk[2] = 8'h30; ll[2] = 1'b1; nsl[2] = 3;
        e_out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bd = {$urandom, $urandom};
            @(negedge clk);
            e_in_data = bd; e_in_keep = kk[b]; e_in_last = ll[b]; e_in_valid = 1'b1;
            @(posedge clk); #1;
            e_in_valid = 1'b0;
            for (int s = 0; s < nsl[b]; s++) begin
                ek = kk[b][s*2 +: 2];
                n_vec++;
                if ({e_out_valid, e_out_last, e_out_keep, e_out_data} !== {1'b1, (ll[b] && s == nsl[b]-1), ek, bd[s*16 +: 16]}) begin
                    n_err++;
                    $display("FAIL zero_keep[%0d.%0d]: got %h expected %h", b, s,
                             {e_out_valid, e_out_last, e_out_keep, e_out_data}, {1'b1, (ll[b] && s == nsl[b]-1), ek, bd[s*16 +: 16]});
                end
                @(posedge clk); #1;
            end
            n_vec++;
            if (e_out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL zero_keep_end[%0d]: out_valid=%b expected 0", b, e_out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [109:0] exp_v;
        u_out_ready = 1'b1;
        up_drive(32'hDEADBEEF, 4'hF, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        u_in_data = 32'h5A5A5A5A; u_in_keep = 4'hF; u_in_last = 1'b1; u_in_valid = 1'b1;
        #1;
        n_vec++;
        if ({u_in_ready, u_out_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid_up_during: ready/valid=%b expected 00", {u_in_ready, u_out_valid});
        end
        @(posedge clk); #1;
        n_vec++;
        if ({u_in_ready, u_out_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid_up_after_edge: ready/valid=%b expected 00", {u_in_ready, u_out_valid});
        end
        @(negedge clk);
        rst = 1'b0; u_in_valid = 1'b0;
        up_drive(32'h13121110, 4'hF, 1'b0);
        n_vec++;
        if (u_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_up_stale: out_valid=%b expected 0", u_out_valid);
        end
        up_drive(32'h23222120, 4'hF, 1'b1);
        exp_v = {1'b1, 1'b1, 12'h0FF, 32'h0, 32'h23222120, 32'h13121110};
        n_vec++;
        if ({u_out_valid, u_out_last, u_out_keep, u_out_data} !== exp_v) begin
            n_err++;
            $display("FAIL rst_mid_up_fresh: got %h expected %h", {u_out_valid, u_out_last, u_out_keep, u_out_data}, exp_v);
        end
        // Downsize: a held beat is discarded by reset.
        d_out_ready = 1'b0;
        @(negedge clk);
        d_in_data = {$urandom, $urandom, $urandom}; d_in_keep = 12'hFFF; d_in_last = 1'b1; d_in_valid = 1'b1;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
        n_vec++;
        if (d_out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_dn_hold: out_valid=%b expected 1", d_out_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({d_out_valid, d_in_ready} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid_dn: valid/ready=%b expected 00", {d_out_valid, d_in_ready});
        end
        @(negedge clk);
        rst = 1'b0; d_out_ready = 1'b1;
        #1;
        n_vec++;
        if ({d_out_valid, d_in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL rst_mid_dn_release: valid/ready=%b expected 01", {d_out_valid, d_in_ready});
        end
    endtask

    task automatic test_random_up();
        logic [109:0] exp_q [$];
        logic [109:0] got, want, saved;
        logic [95:0]  gd;
        logic [11:0]  gk;
        int           gn = 0;
        int           accepted = 0;
        int           cyc = 0;
        logic         stall_prev = 1'b0;
        gd = '0; gk = '0; saved = '0;
        while ((accepted < 1000 || exp_q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            if (stall_prev) begin
                n_vec++;
                if ({u_out_valid, u_out_last, u_out_keep, u_out_data} !== saved) begin
                    n_err++;
                    $display("FAIL rand_up_stall: got %h expected %h", {u_out_valid, u_out_last, u_out_keep, u_out_data}, saved);
                end
            end
            if (accepted < 1000) begin
                u_in_valid = ($urandom_range(0, 9) < 8);
                u_in_data  = $urandom;
                u_in_keep  = 4'($urandom);
                u_in_last  = ($urandom_range(0, 3) == 0) || (accepted == 999);
            end else begin
                u_in_valid = 1'b0;
            end
            u_out_ready = ($urandom_range(0, 9) >= 3);
            #1;
            n_vec++;
            if (u_in_ready !== (!u_out_valid || u_out_ready)) begin
                n_err++;
                $display("FAIL rand_up_ready: got %b with out_valid=%b out_ready=%b", u_in_ready, u_out_valid, u_out_ready);
            end
            if (u_out_valid && u_out_ready) begin
                got = {u_out_valid, u_out_last, u_out_keep, u_out_data};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_up_extra: got %h expected no output", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL rand_up_data: got %h expected %h", got, want);
                    end
                end
            end
            if (u_in_valid && u_in_ready) begin
                gd[gn*32 +: 32] = u_in_data;
                gk[gn*4 +: 4]   = u_in_keep;
                gn++;
                accepted++;
                if (gn == 3 || u_in_last) begin
                    exp_q.push_back({1'b1, u_in_last, gk, gd});
                    gd = '0; gk = '0; gn = 0;
                end
            end
            stall_prev = u_out_valid && !u_out_ready;
            saved = {u_out_valid, u_out_last, u_out_keep, u_out_data};
            cyc++;
        end
        u_in_valid = 1'b0;
        n_vec++;
        if (accepted < 1000 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rand_up_timeout: accepted %0d pending %0d, expected 1000 and 0", accepted, exp_q.size());
        end
    endtask

    task automatic test_random_down();
        logic [37:0] exp_q [$];
        logic [36:0] got;
        logic [37:0] want;
        logic [37:0] saved;
        logic [11:0] kk;
        logic        fin;
        int          n;
        int          accepted = 0;
        int          cyc = 0;
        logic        stall_prev = 1'b0;
        saved = '0;
        while ((accepted < 1000 || exp_q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            if (stall_prev) begin
                n_vec++;
                if ({d_out_valid, d_out_last, d_out_keep, d_out_data} !== saved) begin
                    n_err++;
                    $display("FAIL rand_dn_stall: got %h expected %h", {d_out_valid, d_out_last, d_out_keep, d_out_data}, saved);
                end
            end
            if (accepted < 1000) begin
                kk = 12'($urandom);
                case ($urandom_range(0, 7))
                    0:       kk = kk & 12'h00F;
                    1, 2:    kk = kk & 12'h0FF;
                    3:       kk = '0;
                    default: kk = kk;
                endcase
                d_in_valid = ($urandom_range(0, 9) < 8);
                d_in_data  = {$urandom, $urandom, $urandom};
                d_in_keep  = kk;
                d_in_last  = ($urandom_range(0, 3) == 0);
            end else begin
                d_in_valid = 1'b0;
            end
            d_out_ready = ($urandom_range(0, 9) >= 3);
            #1;
            fin = (exp_q.size() != 0) ? exp_q[0][37] : 1'b0;
            n_vec++;
            if (d_in_ready !== (!d_out_valid || (d_out_ready && fin))) begin
                n_err++;
                $display("FAIL rand_dn_ready: got %b with out_valid=%b out_ready=%b final=%b",
                         d_in_ready, d_out_valid, d_out_ready, fin);
            end
            if (d_out_valid && d_out_ready) begin
                got = {d_out_last, d_out_keep, d_out_data};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_dn_extra: got %h expected no output", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want[36:0]) begin
                        n_err++;
                        $display("FAIL rand_dn_data: got %h expected %h", got, want[36:0]);
                    end
                end
            end
            if (d_in_valid && d_in_ready) begin
                n = 1;
                for (int s = 0; s < 3; s++) if (d_in_keep[s*4 +: 4] != 4'h0) n = s + 1;
                for (int s = 0; s < n; s++)
                    exp_q.push_back({(s == n-1), (d_in_last && s == n-1), d_in_keep[s*4 +: 4], d_in_data[s*32 +: 32]});
                accepted++;
            end
            stall_prev = d_out_valid && !d_out_ready;
            saved = {d_out_valid, d_out_last, d_out_keep, d_out_data};
            cyc++;
        end
        d_in_valid = 1'b0;
        n_vec++;
        if (accepted < 1000 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rand_dn_timeout: accepted %0d pending %0d, expected 1000 and 0", accepted, exp_q.size());
        end
    endtask

    initial begin
        u_in_data = '0; u_in_keep = '0; u_in_last = 1'b0; u_in_valid = 1'b0; u_out_ready = 1'b0;
        d_in_data = '0; d_in_keep = '0; d_in_last = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0;
        z_in_data = '0; z_in_keep = '0; z_in_last = 1'b0; z_in_valid = 1'b0; z_out_ready = 1'b0;
        e_in_data = '0; e_in_keep = '0; e_in_last = 1'b0; e_in_valid = 1'b0; e_out_ready = 1'b0;
        p_in_data = '0; p_in_keep = '0; p_in_last = 1'b0; p_in_valid = 1'b0; p_out_ready = 1'b0;

        test_reset();
        test_passthrough();
        test_up_steady();
        test_up_short();
        test_down_drop();
        test_zero_keep();
        test_reset_mid();
        test_random_up();
        test_random_down();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
